sum_scheduler: RTL and testbench

SUM_SCHEDULER -- requirements
Module: sum_scheduler

---
 rtl/sum_scheduler.sv | 91 +++++++++
 tb/tb_sum_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_scheduler.sv
// Two-requester round-robin scheduler for a serial triangular-sum engine.
// A granted operand n is reduced to n + (n-1) + ... + 1, one term per cycle.
module sum_scheduler #(
    parameter int N_W   = 4,
    parameter int RES_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [N_W-1:0]   n0,
    input  logic             req1,
    input  logic [N_W-1:0]   n1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [RES_W-1:0] result
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state, state_d;
    logic [N_W-1:0]   cnt;
    logic [RES_W-1:0] acc;
    logic             owner;
    logic             last_id;
    logic             grant;
    logic             grant_id;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state;
        grant    = 1'b0;
        grant_id = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant    = 1'b1;
                    grant_id = (req0 && req1) ? ~last_id : req1;
                    state_d  = ACC;
                end
            end
            ACC:     if (cnt == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // last_id resets to 1 so requester 0 wins the first contended arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            result  <= '0;
            acc     <= '0;
            cnt     <= '0;
            owner   <= 1'b0;
            last_id <= 1'b1;
        end else begin
            gnt0 <= grant && !grant_id;
            gnt1 <= grant && grant_id;
            done <= (state == ACC) && (cnt == '0);
            if (grant) begin
                cnt     <= grant_id ? n1 : n0;
                acc     <= '0;
                owner   <= grant_id;
                last_id <= grant_id;
            end else if (state == ACC) begin
                if (cnt != '0) begin
                    acc <= acc + RES_W'(cnt);
                    cnt <= cnt - 1'b1;
                end else begin
                    result  <= acc;
                    done_id <= owner;
                end
            end
        end
    end

endmodule

// File: tb/tb_sum_scheduler.sv
// Self-checking bench for sum_scheduler: vector table plus scoreboard of
// expected results keyed on observed grants.
module tb_sum_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] n0 = '0, n1 = '0;
    logic       gnt0, gnt1, busy, done, done_id;
    logic [6:0] result;

    sum_scheduler #(.N_W(4), .RES_W(7)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .n0(n0), .req1(req1), .n1(n1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .done(done), .done_id(done_id), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct { logic id; int res; int due; } exp_t;
    typedef struct { logic id; int n; int res; int lat; } vec_t;

    exp_t sb[$];
    int   gnt_ids[$];
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0;
    int   gnt_count = 0, done_count = 0;
    int   gnt_cyc = 0, done_cyc = 0, done_res = 0;
    logic last_gnt_id = 1'b0;
    logic in_job = 1'b0;
    logic hold = 1'b0;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor/scoreboard: expected result is pushed when a grant is seen,
    // using the operand the bench was holding for that requester.
    initial begin
        exp_t e;
        int   nn;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (gnt0 || gnt1) begin
                    check("gnt_exclusive", int'(gnt0 && gnt1), 0);
                    nn    = gnt1 ? int'(n1) : int'(n0);
                    e.id  = gnt1;
                    e.res = nn * (nn + 1) / 2;
                    e.due = cyc + nn + 1;
                    sb.push_back(e);
                    gnt_ids.push_back(int'(gnt1));
                    gnt_count++;
                    gnt_cyc     = cyc;
                    last_gnt_id = gnt1;
                    in_job      = 1'b1;
                    if (gnt0 && !hold) req0 = 1'b0;
                    if (gnt1 && !hold) req1 = 1'b0;
                end
                if (in_job) check("busy_in_job", int'(busy), 1);
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_done_id", int'(done_id), int'(e.id));
                        check("sb_result", int'(result), e.res);
                        check("sb_done_cycle", cyc, e.due);
                    end
                    done_count++;
                    done_cyc = cyc;
                    done_res = int'(result);
                    in_job   = 1'b0;
                end
            end
        end
    end

    task automatic wait_gnt(input int target, input string name);
        int k = 0;
        while (gnt_count < target && k < 60) begin
            tick();
            k++;
        end
        check(name, int'(gnt_count >= target), 1);
    endtask

    task automatic wait_done(input int target, input string name);
        int k = 0;
        while (done_count < target && k < 60) begin
            tick();
            k++;
        end
        check(name, int'(done_count >= target), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt0"}, int'(gnt0), 0);
        check({tag, "_gnt1"}, int'(gnt1), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_done_id"}, int'(done_id), 0);
        check({tag, "_result"}, int'(result), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        sb.delete();
        in_job = 1'b0;
        tick();
        check_reset_outputs(tag);
        tick();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int g0 = gnt_count;
        int d0 = done_count;
        if (v.id) begin n1 = 4'(v.n); req1 = 1'b1; end
        else      begin n0 = 4'(v.n); req0 = 1'b1; end
        wait_gnt(g0 + 1, "vec_gnt_seen");
        check("vec_gnt_id", int'(last_gnt_id), int'(v.id));
        wait_done(d0 + 1, "vec_done_seen");
        check("vec_latency", done_cyc - gnt_cyc, v.lat);
        check("vec_result", done_res, v.res);
        tick();
        check("vec_busy_idle", int'(busy), 0);
        tick();
    endtask

    initial begin
        int g0, d0;
        vecs[0] = '{id: 1'b0, n: 4,  res: 10,  lat: 5};
        vecs[1] = '{id: 1'b1, n: 15, res: 120, lat: 16};
        vecs[2] = '{id: 1'b0, n: 0,  res: 0,   lat: 1};
        vecs[3] = '{id: 1'b1, n: 7,  res: 28,  lat: 8};
        vecs[4] = '{id: 1'b0, n: 1,  res: 1,   lat: 2};
        vecs[5] = '{id: 1'b0, n: 15, res: 120, lat: 16};

        tick();
        do_reset("rst_init");
        tick();

        foreach (vecs[k]) run_vec(vecs[k]);

        // Contention from reset priority: 0, then 1, then 0 again.
        do_reset("rst_contend");
        gnt_ids.delete();
        g0 = gnt_count;
        d0 = done_count;
        hold = 1'b1;
        n0 = 4'd3; n1 = 4'd5;
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(g0 + 3, "contend_gnts_seen");
        hold = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        check("contend_order_0", gnt_ids.size() > 0 ? gnt_ids[0] : -1, 0);
        check("contend_order_1", gnt_ids.size() > 1 ? gnt_ids[1] : -1, 1);
        check("contend_order_2", gnt_ids.size() > 2 ? gnt_ids[2] : -1, 0);
        wait_done(d0 + 3, "contend_done_seen");
        check("contend_last_result", done_res, 6);
        repeat (3) tick();

        // Abort: reset during the 4th ACC cycle of an n=10 job.
        g0 = gnt_count;
        d0 = done_count;
        n0 = 4'd10; req0 = 1'b1;
        wait_gnt(g0 + 1, "abort_gnt_seen");
        repeat (3) tick();
        rst = 1'b1;
        sb.delete();
        in_job = 1'b0;
        tick();
        check_reset_outputs("rst_abort");
        rst = 1'b0;
        repeat (15) tick();
        check("abort_no_done", done_count, d0);
        check("abort_idle", int'(busy), 0);
        run_vec('{id: 1'b1, n: 2, res: 3, lat: 3});

        // Operand change after grant must not affect the running job.
        g0 = gnt_count;
        d0 = done_count;
        n0 = 4'd6; req0 = 1'b1;
        wait_gnt(g0 + 1, "opchg_gnt_seen");
        n0 = 4'd9;
        wait_done(d0 + 1, "opchg_done_seen");
        check("opchg_result", done_res, 21);
        repeat (3) tick();

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
